uart_rx_mmio: RTL and testbench

//  Receive half of the jacaranda-8 UART: 8N1 serial deserializer with a one-byte holding register.

---
 rtl/uart_rx_mmio_if.sv | 17 +
 rtl/uart_rx_mmio.sv | 122 ++++++++++++
 tb/tb_uart_rx_mmio.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: CPU-side and pin-side signal bundle of the UART receiver.
interface uart_rx_mmio_if;
    logic       rx_en;
    logic       rx;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       receive_flag;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;
    modport master (output rx_en, rx, rd_ack,
                    input  rx_data, rx_valid, receive_flag, frame_err, overrun, parity_err, busy);
    modport slave  (input  rx_en, rx, rd_ack,
                    output rx_data, rx_valid, receive_flag, frame_err, overrun, parity_err, busy);
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with a one-byte holding register and sticky status flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 434
) (
    input logic           i_clock,
    input logic           i_reset_n,
    uart_rx_mmio_if.slave bus
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_sync;
    logic [W-1:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_flag;
    logic       r_ferr;
    logic       r_ovr;
    logic       w_rx_s;
    logic       w_full;
    logic       w_shift;
    logic       w_commit;
    logic       w_ferr;

    assign w_rx_s = r_sync[1];
    assign w_full = r_cnt == FULL;

    always_comb begin
        w_next   = r_state;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_ferr   = 1'b0;
        if (r_state != IDLE && !bus.rx_en)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:      if (bus.rx_en && !w_rx_s) w_next = START;
                START:     if (r_cnt == HALF) w_next = w_rx_s ? IDLE : DATA;
                DATA:      if (w_full) begin
                    w_shift = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (r_bit_idx == 3'd7) w_next = PARITY;
`else
                    if (r_bit_idx == 3'd7) w_next = STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY:    if (w_full) w_next = STOP;
`endif
                STOP:      if (w_full) begin
                    w_commit = w_rx_s;
                    w_ferr   = !w_rx_s;
                    w_next   = w_rx_s ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: if (w_rx_s) w_next = IDLE;
                default:   w_next = IDLE;
            endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_sync    <= 2'b11;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_next;
            r_sync    <= {r_sync[0], bus.rx};
            r_cnt     <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
            r_bit_idx <= (r_state != DATA) ? '0 : r_bit_idx + 3'(w_shift);
            r_shift   <= w_shift ? {w_rx_s, r_shift[7:1]} : r_shift;
        end
    end

    // An acknowledge in the same cycle as a commit clears old state, then this commit's flags win.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_flag  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_data  <= w_commit ? r_shift : r_data;
            r_valid <= w_commit | (r_valid & ~bus.rd_ack);
            r_flag  <= w_commit;
            r_ferr  <= w_ferr | (r_ferr & ~bus.rd_ack);
            r_ovr   <= (w_commit & r_valid & ~bus.rd_ack) | (r_ovr & ~bus.rd_ack);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic w_perr;
    assign w_perr = r_state == PARITY && w_full && bus.rx_en && (^{r_shift, w_rx_s});
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_perr <= 1'b0;
        else
            r_perr <= w_perr | (r_perr & ~bus.rd_ack);
    end
    assign bus.parity_err = r_perr;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rx_data      = r_data;
    assign bus.rx_valid     = r_valid;
    assign bus.receive_flag = r_flag;
    assign bus.frame_err    = r_ferr;
    assign bus.overrun      = r_ovr;
    assign bus.busy         = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed bench for uart_rx_mmio at CLKS_PER_BIT=16.
module tb_uart_rx_mmio;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic clock = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   flag_cnt = 0;
    int   flag_at = 0;
    int   lat;

    uart_rx_mmio_if bus ();

    uart_rx_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .i_clock  (clock),
        .i_reset_n(reset_n),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.receive_flag) begin
                flag_cnt++;
                flag_at = cyc;
            end
        end
    endtask

    // Sends one frame; ack_at is the frame-relative edge at which rd_ack is seen high (0 = never).
    task automatic send(input logic [7:0] d, input logic stop, input logic par, input int ack_at,
                        output int l);
        logic [10:0] f;
        int nb;
        int c0;
        f  = {stop, par, d, 1'b0};
        nb = 11;
`ifndef UART_RX_PARITY_EN
        f[9] = stop;
        nb   = 10;
`endif
        c0 = cyc;
        flag_cnt = 0;
        flag_at  = 0;
        for (int b = 0; b < nb; b++) begin
            bus.rx = f[b];
            for (int c = 0; c < CPB; c++) begin
                bus.rd_ack = (cyc - c0 == ack_at - 1);
                tick(1);
            end
        end
        bus.rd_ack = 1'b0;
        l = (flag_at != 0) ? flag_at - c0 : 0;
    endtask

    task automatic ack();
        bus.rd_ack = 1'b1;
        tick(1);
        bus.rd_ack = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.rx     = 1'b1;
        bus.rx_en  = 1'b1;
        bus.rd_ack = 1'b0;
        tick(3);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_data", 32'(bus.rx_data), 0);
        reset_n = 1'b1;
        tick(3);
        chk("rst_valid", 32'(bus.rx_valid), 0);
        chk("rst_flags", 32'({bus.receive_flag, bus.frame_err, bus.overrun, bus.parity_err}), 0);

        // single good byte, exact latency
        send(8'h55, 1'b1, 1'b0, 0, lat);
        chk("t1_lat", 32'(lat), 32'(LAT));
        chk("t1_flag_cnt", 32'(flag_cnt), 1);
        chk("t1_data", 32'(bus.rx_data), 32'h55);
        chk("t1_valid", 32'(bus.rx_valid), 1);
        chk("t1_ferr", 32'(bus.frame_err), 0);
        ack();
        chk("t1_ack_valid", 32'(bus.rx_valid), 0);

        // short low glitch aborts in START
        flag_cnt = 0;
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        chk("t2_busy_hi", 32'(bus.busy), 1);
        tick(12);
        chk("t2_busy_lo", 32'(bus.busy), 0);
        chk("t2_flag", 32'(flag_cnt), 0);
        chk("t2_valid", 32'(bus.rx_valid), 0);

        // rx_en dropped mid-frame
        bus.rx = 1'b0;
        tick(40);
        chk("en_busy_hi", 32'(bus.busy), 1);
        bus.rx_en = 1'b0;
        tick(1);
        chk("en_busy_lo", 32'(bus.busy), 0);
        bus.rx = 1'b1;
        tick(20);
        chk("en_flags", 32'({flag_cnt != 0, bus.rx_valid, bus.frame_err}), 0);
        bus.rx_en = 1'b1;
        tick(2);

        // framing error, break held, then good byte
        send(8'hA3, 1'b0, 1'b0, 0, lat);
        chk("t3_noflag", 32'(flag_cnt), 0);
        tick(40);
        chk("t3_ferr", 32'(bus.frame_err), 1);
        chk("t3_valid", 32'(bus.rx_valid), 0);
        chk("t3_wait_busy", 32'(bus.busy), 1);
        bus.rx = 1'b1;
        tick(4);
        chk("t3_idle", 32'(bus.busy), 0);
        send(8'h3C, 1'b1, 1'b0, 0, lat);
        chk("t3_lat", 32'(lat), 32'(LAT));
        chk("t3_data", 32'(bus.rx_data), 32'h3C);
        chk("t3_ferr_sticky", 32'(bus.frame_err), 1);
        ack();
        chk("t3_ack", 32'({bus.rx_valid, bus.frame_err}), 0);

        // overrun
        send(8'h11, 1'b1, 1'b0, 0, lat);
        send(8'h22, 1'b1, 1'b0, 0, lat);
        chk("t4_ovr", 32'(bus.overrun), 1);
        chk("t4_data", 32'(bus.rx_data), 32'h22);
        chk("t4_valid", 32'(bus.rx_valid), 1);
        ack();
        chk("t4_ack", 32'({bus.rx_valid, bus.overrun}), 0);

        // rd_ack coincident with a commit
        send(8'h44, 1'b1, 1'b0, 0, lat);
        send(8'h66, 1'b1, 1'b0, LAT, lat);
        chk("sim_ovr", 32'(bus.overrun), 0);
        chk("sim_valid", 32'(bus.rx_valid), 1);
        chk("sim_data", 32'(bus.rx_data), 32'h66);

        // reset during data bit 3 with a byte held
        bus.rx = 1'b0;
        tick(CPB + 3 * CPB + CPB / 2);
        chk("t5_busy_pre", 32'(bus.busy), 1);
        reset_n = 1'b0;
        bus.rx  = 1'b1;
        #1;
        chk("t5_rst_data", 32'(bus.rx_data), 0);
        chk("t5_rst_out", 32'({bus.rx_valid, bus.receive_flag, bus.frame_err, bus.overrun,
                              bus.parity_err, bus.busy}), 0);
        tick(3);
        chk("t5_rst_hold", 32'({bus.rx_valid, bus.busy}), 0);
        reset_n = 1'b1;
        tick(2);
        send(8'hF0, 1'b1, 1'b0, 0, lat);
        chk("t5_lat", 32'(lat), 32'(LAT));
        chk("t5_data", 32'(bus.rx_data), 32'hF0);
        ack();

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 0, lat);
        chk("t6_perr_ok", 32'(bus.parity_err), 0);
        chk("t6_data_ok", 32'(bus.rx_data), 32'h07);
        ack();
        send(8'h07, 1'b1, 1'b0, 0, lat);
        chk("t6_perr_bad", 32'(bus.parity_err), 1);
        chk("t6_data_bad", 32'(bus.rx_data), 32'h07);
        chk("t6_valid_bad", 32'(bus.rx_valid), 1);
        ack();
        chk("t6_ack", 32'({bus.rx_valid, bus.parity_err}), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
